// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared types, default widths and saturating helpers for the move sequencer
package sm_pkg;

  localparam int SIZE_DEF  = 16;
  localparam int CNT_W_DEF = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE_ON,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_SETTLE_OFF,
    S_DONE
  } state_t;

  // Operands are zero-extended period values; the 33-bit sum never wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, hi}) ? hi : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lo);
    if (a < b) return lo;
    return ((a - b) < lo) ? lo : (a - b);
  endfunction

endpackage

// File: rtl/sm_move_ctrl_step_timer.sv
// rtl/sm_move_ctrl_step_timer.sv - period counter, step pulse shaping and wrap strobe
module sm_step_timer #(
  parameter int SIZE    = 16,
  parameter int PULSE_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_i,
  input  logic [SIZE-1:0] period_i,
  output logic            step_o,
  output logic            wrap_o
);

  logic [SIZE-1:0] pc_q;

  assign wrap_o = run_i && (pc_q == period_i - SIZE'(1));
  assign step_o = run_i && (pc_q < SIZE'(PULSE_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pc_q <= '0;
    else if (!run_i || wrap_o) pc_q <= '0;
    else                      pc_q <= pc_q + SIZE'(1);
  end

endmodule

// File: rtl/sm_move_ctrl.sv
// rtl/sm_move_ctrl.sv - trapezoidal-profile move sequencer for one stepper axis
module sm_move_ctrl
  import sm_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int SETTLE_CYC = 1000,
  parameter int PULSE_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             limit,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [SIZE-1:0]  period_max,
  input  logic [SIZE-1:0]  period_min,
  input  logic [SIZE-1:0]  ramp_dec,
  output logic             drv_enable,
  output logic             drv_dir,
  output logic             drv_step,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] steps_done,
  output logic [SIZE-1:0]  period_cur
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SIZE-1:0] P_FLOOR = SIZE'(PULSE_W + 1);

  state_t           state_q, state_d;
  logic             dir_q, dir_d, abort_q, abort_d, fault_q, fault_d;
  logic [CNT_W-1:0] steps_q, steps_d, sd_q, sd_d, lvl_q, lvl_d;
  logic [SIZE-1:0]  pmax_q, pmax_d, pmin_q, pmin_d, ramp_q, ramp_d, period_q, period_d;
  logic [SW-1:0]    set_q, set_d;

  logic             run, step_w, wrap_w, ab, set_last;
  logic [SIZE-1:0]  pmax_in, pmin_t, pmin_in, period_up, period_dn;
  logic [CNT_W-1:0] sd_inc, rem, lvl_inc, lvl_dec;

  assign run = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);

  sm_step_timer #(.SIZE(SIZE), .PULSE_W(PULSE_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run),
    .period_i(period_q),
    .step_o  (step_w),
    .wrap_o  (wrap_w)
  );

  assign pmax_in   = (period_max < P_FLOOR) ? P_FLOOR : period_max;
  assign pmin_t    = (period_min < P_FLOOR) ? P_FLOOR : period_min;
  assign pmin_in   = (pmin_t > pmax_in) ? pmax_in : pmin_t;
  assign period_up = SIZE'(sat_add(32'(period_q), 32'(ramp_q), 32'(pmax_q)));
  assign period_dn = SIZE'(sat_sub(32'(period_q), 32'(ramp_q), 32'(pmin_q)));
  assign sd_inc    = sd_q + CNT_W'(1);
  assign rem       = steps_q - sd_inc;
  assign lvl_inc   = (&lvl_q) ? lvl_q : lvl_q + CNT_W'(1);
  assign lvl_dec   = (lvl_q == '0) ? lvl_q : lvl_q - CNT_W'(1);
  // A pulse arriving on the same cycle as the wrap still counts as latched.
  assign ab        = abort_q || abort;
  assign set_last  = (set_q == SW'(SETTLE_CYC - 1));

  assign drv_enable = (state_q == S_SETTLE_ON) || run || (state_q == S_SETTLE_OFF);
  assign drv_dir    = dir_q;
  assign drv_step   = step_w;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign fault      = fault_q;
  assign steps_done = sd_q;
  assign period_cur = period_q;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    abort_d  = abort_q;
    fault_d  = fault_q;
    steps_d  = steps_q;
    sd_d     = sd_q;
    lvl_d    = lvl_q;
    pmax_d   = pmax_q;
    pmin_d   = pmin_q;
    ramp_d   = ramp_q;
    period_d = period_q;
    set_d    = set_q;
    if (state_q != S_IDLE && abort) abort_d = 1'b1;
    case (state_q)
      S_IDLE: if (start) begin
        dir_d    = dir;
        steps_d  = steps;
        pmax_d   = pmax_in;
        pmin_d   = pmin_in;
        ramp_d   = ramp_dec;
        period_d = pmax_in;
        sd_d     = '0;
        lvl_d    = '0;
        fault_d  = 1'b0;
        abort_d  = 1'b0;
        set_d    = '0;
        state_d  = (steps == '0) ? S_DONE : S_SETTLE_ON;
      end
      S_SETTLE_ON: begin
        if (ab) state_d = S_DONE;
        else if (set_last) begin
          set_d   = '0;
          state_d = (pmin_q == pmax_q) ? S_CRUISE : S_ACCEL;
        end else set_d = set_q + SW'(1);
      end
      S_ACCEL, S_CRUISE, S_DECEL: if (wrap_w) begin
        sd_d = sd_inc;
        if (rem == '0) state_d = S_SETTLE_OFF;
        else if (rem <= lvl_q || ab) begin
          if (ab && lvl_q == '0) state_d = S_SETTLE_OFF;
          else begin
            state_d  = S_DECEL;
            period_d = period_up;
            lvl_d    = lvl_dec;
          end
        end else if (state_q == S_ACCEL) begin
          period_d = period_dn;
          lvl_d    = lvl_inc;
          if (period_dn == pmin_q) state_d = S_CRUISE;
        end
      end
      S_SETTLE_OFF: begin
        if (set_last) begin
          set_d   = '0;
          state_d = S_DONE;
        end else set_d = set_q + SW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Hard stop wins over everything; an interrupted step is not counted.
    if (limit && busy && state_q != S_DONE) begin
      state_d  = S_DONE;
      fault_d  = 1'b1;
      sd_d     = sd_q;
      lvl_d    = lvl_q;
      period_d = period_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      abort_q  <= 1'b0;
      fault_q  <= 1'b0;
      steps_q  <= '0;
      sd_q     <= '0;
      lvl_q    <= '0;
      pmax_q   <= '0;
      pmin_q   <= '0;
      ramp_q   <= '0;
      period_q <= '0;
      set_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      abort_q  <= abort_d;
      fault_q  <= fault_d;
      steps_q  <= steps_d;
      sd_q     <= sd_d;
      lvl_q    <= lvl_d;
      pmax_q   <= pmax_d;
      pmin_q   <= pmin_d;
      ramp_q   <= ramp_d;
      period_q <= period_d;
      set_q    <= set_d;
    end
  end

endmodule

// File: tb/tb_sm_move_ctrl.sv
// tb/tb_sm_move_ctrl.sv - directed self-checking bench for sm_move_ctrl
module tb_sm_move_ctrl;

  localparam int SIZE = 16, CNT_W = 24, SETTLE = 20, PW = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort, limit, dir;
  logic [CNT_W-1:0] steps;
  logic [SIZE-1:0]  period_max, period_min, ramp_dec;
  logic             drv_enable, drv_dir, drv_step, busy, done, fault;
  logic [CNT_W-1:0] steps_done;
  logic [SIZE-1:0]  period_cur;

  int vectors = 0, miscompares = 0, cyc = 0;
  int rise_q[$], per_q[$], width_q[$];
  int en_rise = 0, last_rise = 0, dcyc = 0;
  bit en_seen = 0, step_prev = 0, en_prev = 0;

  sm_move_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE), .PULSE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .limit(limit), .dir(dir),
    .steps(steps), .period_max(period_max), .period_min(period_min), .ramp_dec(ramp_dec),
    .drv_enable(drv_enable), .drv_dir(drv_dir), .drv_step(drv_step), .busy(busy),
    .done(done), .fault(fault), .steps_done(steps_done), .period_cur(period_cur)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (drv_step && !step_prev) begin
      rise_q.push_back(cyc);
      per_q.push_back(int'(period_cur));
      last_rise = cyc;
    end
    if (!drv_step && step_prev) width_q.push_back(cyc - last_rise);
    if (drv_enable && !en_prev) en_rise = cyc;
    if (drv_enable) en_seen = 1'b1;
    step_prev = drv_step;
    en_prev   = drv_enable;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input int n, input int pmax, input int pmin, input int dec, input bit d);
    steps = CNT_W'(n); period_max = SIZE'(pmax); period_min = SIZE'(pmin);
    ramp_dec = SIZE'(dec); dir = d;
    rise_q.delete(); per_q.delete(); width_q.delete(); en_seen = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    dcyc = cyc;
  endtask

  task automatic check_move(input string tag, input int exp[$]);
    check({tag, "_nsteps"}, per_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < per_q.size(); i++) begin
      check({tag, "_period"}, per_q[i], exp[i]);
      if (i > 0) check({tag, "_interval"}, rise_q[i] - rise_q[i-1], exp[i-1]);
    end
    for (int i = 0; i < width_q.size(); i++) check({tag, "_width"}, width_q[i], PW);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; limit = 1'b0; dir = 1'b0;
    steps = '0; period_max = '0; period_min = '0; ramp_dec = '0;
    repeat (3) @(negedge clk);
    check("rst_enable", drv_enable, 0);
    check("rst_step", drv_step, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_steps_done", steps_done, 0);
    check("rst_period", period_cur, 0);
    rst = 1'b0;
    @(negedge clk);

    // zero-step move: immediate done, driver never enabled
    cmd(0, 10, 10, 0, 0);
    check("zero_done", done, 1);
    @(negedge clk);
    check("zero_done_pulse", done, 0);
    check("zero_busy", busy, 0);
    check("zero_enable_seen", en_seen, 0);
    check("zero_steps_done", steps_done, 0);

    // flat profile, settle timing
    cmd(5, 10, 10, 0, 1);
    check("flat_dir", drv_dir, 1);
    check("flat_enable", drv_enable, 1);
    wait_done(1000);
    check_move("flat", '{10, 10, 10, 10, 10});
    check("flat_settle_on", rise_q.size() > 0 ? rise_q[0] - en_rise : -1, SETTLE);
    check("flat_settle_off", rise_q.size() > 4 ? dcyc - rise_q[4] : -1, 10 + SETTLE);
    check("flat_steps_done", steps_done, 5);
    check("flat_enable_in_done", drv_enable, 0);
    @(negedge clk);
    check("flat_done_pulse", done, 0);
    check("flat_steps_hold", steps_done, 5);

    // full trapezoid
    cmd(10, 100, 40, 20, 0);
    wait_done(3000);
    check_move("trap", '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100});
    check("trap_steps_done", steps_done, 10);
    check("trap_fault", fault, 0);
    @(negedge clk);

    // short move: triangle profile
    cmd(4, 100, 40, 20, 0);
    wait_done(2000);
    check_move("tri", '{100, 80, 60, 80});
    check("tri_steps_done", steps_done, 4);
    @(negedge clk);

    // soft abort during step 5
    cmd(10, 100, 40, 20, 0);
    begin
      int k = 0;
      while (rise_q.size() < 5 && k < 2000) begin @(negedge clk); k++; end
    end
    check("abort_reach_step5", rise_q.size(), 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(2000);
    check_move("abort", '{100, 80, 60, 40, 40, 60, 80, 100});
    check("abort_steps_done", steps_done, 8);
    check("abort_fault", fault, 0);
    @(negedge clk);

    // hard stop mid-pulse of step 3
    cmd(10, 10, 10, 0, 0);
    begin
      int k = 0;
      while (!(drv_step && steps_done == 2) && k < 500) begin @(negedge clk); k++; end
    end
    check("limit_in_pulse", drv_step, 1);
    limit = 1'b1;
    @(negedge clk);
    check("limit_step", drv_step, 0);
    check("limit_enable", drv_enable, 0);
    check("limit_fault", fault, 1);
    check("limit_done", done, 1);
    check("limit_steps_done", steps_done, 2);
    limit = 1'b0;
    @(negedge clk);
    check("limit_idle", busy, 0);
    check("limit_fault_sticky", fault, 1);
    cmd(1, 10, 10, 0, 0);
    check("fault_cleared", fault, 0);
    wait_done(500);
    check("after_limit_steps", steps_done, 1);
    @(negedge clk);

    // reset in the middle of cruise
    cmd(10, 100, 40, 20, 0);
    begin
      int k = 0;
      while (rise_q.size() < 5 && k < 2000) begin @(negedge clk); k++; end
    end
    check("mid_reset_reach", rise_q.size(), 5);
    rst = 1'b1;
    #1;
    check("mid_rst_enable", drv_enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_step", drv_step, 0);
    check("mid_rst_steps_done", steps_done, 0);
    check("mid_rst_period", period_cur, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 0);
    cmd(2, 10, 10, 0, 0);
    wait_done(500);
    check_move("post_rst", '{10, 10});
    check("post_rst_steps", steps_done, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
